song_player: RTL
================

# song_player

Note sequencer downstream of `song_sel`: takes the registered 3-bit song index and steps through that song's note table at a fixed beat rate. It outputs one 5-bit note code per note, followed by a short articulation gap. The buzzer/tone generator consumes `note_code` and maps it to a frequency divider. Songs loop until `play` drops or a different song is selected.

## Interface
- `BEAT_CYC`, 25_000_000: clock cycles per beat (0.25 s at 100 MHz); ≥ `GAP_CYC`+1.
- `GAP_CYC`, 2_500_000: silent cycles inserted after every note.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `song_sel` in 3: song index from `song_sel`; 0–5 valid, 6–7 mean silence.
- `play` in 1: level enable; 1 = sequence, 0 = idle/silent.
- `note_code` out 5: current note; 0 = rest/silence, 1–30 = pitch codes.
- `note_start` out 1: one-cycle pulse on the first cycle a new note is driven in PLAY.
- `loop_pulse` out 1: one-cycle pulse when the end marker wraps the song to entry 0.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Note table: 6 songs × 32 entries, each entry 7 bits `{dur[1:0], note[4:0]}`.
  - Duration is `dur+1` beats (1–4).
  - `note`=31 is the end marker.
- ROM is synchronous: 1-cycle read latency, address `{song_sel, idx[4:0]}`.
- States:
  - **IDLE**: `note_code`=0, `idx`=0. Go to FETCH when `play`=1 and `song_sel`≤5.
  - **FETCH**: ROM read in progress; `note_code`=0.
    - Next is PLAY, or WRAP if the returned note is 31.
    - `idx`=31 without an end marker also wraps.
  - **PLAY**: `note_code`=entry note, held for `(dur+1)*BEAT_CYC − GAP_CYC` cycles, then GAP.
  - **GAP**: `note_code`=0 for `GAP_CYC` cycles, then `idx`+1 → FETCH.
  - **WRAP**: `idx`=0, `loop_pulse`=1 for this cycle, then FETCH.
- Overrides, checked every cycle in priority order:
  1. `rst`.
  2. `play`=0 → IDLE.
  3. `song_sel` ≠ registered previous value → FETCH with `idx`=0. If the new value is 6–7, go to IDLE instead.
- Rest entries (`note`=0) go through PLAY normally. `note_start` still pulses, and `note_code` stays 0.
- Cycle counter is 32-bit unsigned. It loads on entry to PLAY/GAP and counts down to 1. The transition happens on the cycle the counter equals 1.

## Timing
- Reset values: `note_code`=0, `note_start`=0, `loop_pulse`=0, `busy`=0, state IDLE, `idx`=0, prev_sel=0.
- Start latency: `play` is sampled high at edge N, FETCH occupies cycle N+1, and PLAY with a valid `note_code` and `note_start`=1 begins at N+2.
- All outputs are registered or decoded from registered state only; no combinational input→output path.
- Song change: detected at edge N, FETCH at N+1, new song entry 0 on `note_code` at N+2. The old note is cut immediately.
- `play` drop at edge N: `note_code`=0 and `busy`=0 from N+1.
- Simultaneous `play`=0 and song change: `play`=0 wins (IDLE). prev_sel still updates.
- End marker: FETCH → WRAP → FETCH → PLAY, i.e. 3 silent cycles between the last GAP and entry 0.
- Reset asserted mid-note: outputs return to reset values asynchronously.

## Structure
- Package `song_pkg`:
  - `NUM_SONGS`=6, `SONG_LEN`=32, `NOTE_END`=31, `NOTE_REST`=0.
  - State enum `{IDLE, FETCH, PLAY, GAP, WRAP}`.
  - The song table constants.
- Sub-module `note_rom` (inputs `clk`, `addr[7:0]`; output `data[6:0]` registered) holds the table.
- Song 5 is the reserved test pattern: {dur0,note5}, {dur1,note0}, {dur3,note12}, {–,note31}.

## Test plan
All scenarios use `BEAT_CYC`=8, `GAP_CYC`=2, `song_sel`=5 unless stated.
- **Reset/idle**: `rst`=1 then 0 with `play`=0 → `note_code`=0, `busy`=0, no pulses for 50 cycles.
- **Basic sequence**: `play` rises → `note_code`=5 for 6 cycles, 0 for 2, 0 for 14 (rest, with `note_start` pulse), 12 for 30, then 0 for 2.
  - `note_start` pulses exactly 3 times.
  - `loop_pulse` fires 1 cycle later, then 5 reappears 2 cycles after that.
- **Song change mid-note**: switch to song 2 while `note_code`=12 → `note_code`=0 for 1 cycle, then song 2 entry 0, with `note_start` pulse.
- **Invalid song**: `song_sel`=6 while playing → IDLE next cycle, `note_code`=0, `busy`=0. Returning to 5 restarts at entry 0.
- **Play drop and reset race**: `play`=0 and a song change in the same cycle → IDLE. `rst` pulse mid-PLAY clears outputs immediately.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg: shared constants, FSM state type and the note table for song_player.
//   Table entry layout is {dur[1:0], note[4:0]}; the note plays for dur+1 beats.
//   Entries past a song's end marker read back as the end marker.
package song_pkg;

  localparam int NUM_SONGS = 6;
  localparam int SONG_LEN  = 32;
  localparam logic [4:0] NOTE_END  = 5'd31;
  localparam logic [4:0] NOTE_REST = 5'd0;

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, WRAP} state_t;

  typedef logic [6:0] entry_t;

  function automatic entry_t ent(input logic [1:0] dur, input logic [4:0] note);
    return {dur, note};
  endfunction

  // Song 5 is the fixed test pattern; songs 0-4 are short melodies.
  function automatic entry_t song_entry(input logic [2:0] song, input logic [4:0] idx);
    entry_t e;
    e = {2'd0, NOTE_END};
    case (song)
      3'd0: case (idx)
        5'd0: e = ent(2'd0, 5'd1);
        5'd1: e = ent(2'd0, 5'd3);
        5'd2: e = ent(2'd0, 5'd5);
        5'd3: e = ent(2'd1, 5'd6);
        default: ;
      endcase
      3'd1: case (idx)
        5'd0: e = ent(2'd1, 5'd8);
        5'd1: e = ent(2'd0, NOTE_REST);
        5'd2: e = ent(2'd0, 5'd10);
        5'd3: e = ent(2'd2, 5'd12);
        default: ;
      endcase
      3'd2: case (idx)
        5'd0: e = ent(2'd0, 5'd20);
        5'd1: e = ent(2'd0, 5'd18);
        5'd2: e = ent(2'd1, 5'd16);
        default: ;
      endcase
      3'd3: case (idx)
        5'd0: e = ent(2'd3, 5'd2);
        5'd1: e = ent(2'd0, 5'd4);
        default: ;
      endcase
      3'd4: case (idx)
        5'd0: e = ent(2'd0, 5'd30);
        5'd1: e = ent(2'd0, 5'd29);
        5'd2: e = ent(2'd0, 5'd28);
        5'd3: e = ent(2'd0, 5'd27);
        5'd4: e = ent(2'd1, 5'd26);
        default: ;
      endcase
      3'd5: case (idx)
        5'd0: e = ent(2'd0, 5'd5);
        5'd1: e = ent(2'd1, NOTE_REST);
        5'd2: e = ent(2'd3, 5'd12);
        default: ;
      endcase
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/note_rom.sv
// note_rom: synchronous note table, one cycle read latency.
//   clk  - system clock
//   addr - {song[2:0], idx[4:0]}
//   data - registered {dur[1:0], note[4:0]}
module note_rom
  import song_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [6:0] data
);

  always_ff @(posedge clk) data <= song_entry(addr[7:5], addr[4:0]);

endmodule

// File: rtl/song_player.sv
// song_player: steps through the selected song's note table at a fixed beat rate.
//   clk, rst   - clock, async active-high reset
//   song_sel   - song index (0-5 valid, 6-7 silence)
//   play       - level enable
//   note_code  - current note (0 = silence/rest)
//   note_start - pulse on the first PLAY cycle of each note
//   loop_pulse - pulse in the cycle the song wraps to entry 0
//   busy       - high whenever not IDLE
// GAP_CYC is expected to be at least 1.
module song_player
  import song_pkg::*;
#(
  parameter int unsigned BEAT_CYC = 25_000_000,
  parameter int unsigned GAP_CYC  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] song_sel,
  input  logic       play,
  output logic [4:0] note_code,
  output logic       note_start,
  output logic       loop_pulse,
  output logic       busy
);

  localparam int IDX_W = $clog2(SONG_LEN);
  localparam logic [2:0]       LAST_SONG = 3'(NUM_SONGS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SONG_LEN - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [2:0]       prev_sel;
  logic [31:0]      cnt, cnt_nxt;
  logic [4:0]       cur_note, cur_note_nxt;
  logic [6:0]       rom_data;
  logic             sel_valid;

  function automatic logic [31:0] play_len(input logic [1:0] dur);
    return (32'(dur) + 32'd1) * 32'(BEAT_CYC) - 32'(GAP_CYC);
  endfunction

  // Address comes from the next-state index so the entry is already on
  // rom_data during the FETCH cycle itself.
  note_rom u_rom (
    .clk  (clk),
    .addr ({song_sel, idx_nxt}),
    .data (rom_data)
  );

  assign sel_valid = (song_sel <= LAST_SONG);

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    cur_note_nxt = cur_note;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (play && sel_valid) state_nxt = FETCH;
      end
      FETCH: begin
        // The last slot is never played as a note: it always wraps.
        if (rom_data[4:0] == NOTE_END || idx == LAST_IDX) begin
          state_nxt = WRAP;
          idx_nxt   = '0;
        end else begin
          state_nxt    = PLAY;
          cur_note_nxt = rom_data[4:0];
          cnt_nxt      = play_len(rom_data[6:5]);
        end
      end
      PLAY: begin
        if (cnt == 32'd1) begin
          state_nxt = GAP;
          cnt_nxt   = 32'(GAP_CYC);
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      GAP: begin
        if (cnt == 32'd1) begin
          state_nxt = FETCH;
          idx_nxt   = idx + 1'b1;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      WRAP: begin
        state_nxt = FETCH;
        idx_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase

    // Overrides: play drop beats a song change.
    if (!play) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (song_sel != prev_sel) begin
      idx_nxt   = '0;
      state_nxt = sel_valid ? FETCH : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      prev_sel   <= '0;
      cnt        <= '0;
      cur_note   <= NOTE_REST;
      note_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      prev_sel   <= song_sel;
      cnt        <= cnt_nxt;
      cur_note   <= cur_note_nxt;
      note_start <= (state == FETCH) && (state_nxt == PLAY);
    end
  end

  assign note_code  = (state == PLAY) ? cur_note : NOTE_REST;
  assign loop_pulse = (state == WRAP);
  assign busy       = (state != IDLE);

endmodule
